sync_event_arbiter: RTL and testbench
=====================================

Name: sync_event_arbiter

Overview:
- Multi-channel front end for asynchronous status/strobe inputs: each channel gets an ff_sync-style synchronizer plus a rising-edge detector.
- Detected edges are latched as pending events and handed one at a time to a single consumer over a valid/ready interface, using round-robin arbitration.
- Sits between raw async pins (buttons, external strobes, cross-domain flags) and the control logic that sequences the display datapath.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- SYNC_STAGES, 2, synchronizer flop depth per channel (>=2).
- TS_W, 16, timestamp width; used only with SYNC_EVENT_TIMESTAMP_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset; all state clears while low
- signal_in  input  NUM_CH  async inputs, one bit per channel
- sync_level  output  NUM_CH  synchronized level (last synchronizer stage)
- evt_valid  output  1  an event is presented
- evt_ready  input  1  consumer accepts the event when evt_valid && evt_ready at a clk rising edge
- evt_ch  output  $clog2(NUM_CH)  channel index of the presented event
- pending  output  NUM_CH  latched, not-yet-granted events
- overflow  output  NUM_CH  sticky flag: an edge arrived while that channel was already pending
- overflow_clr  input  NUM_CH  per-channel clear of overflow
- evt_ts  output  TS_W  timestamp of the presented event (present only with the macro)

Behaviour:
Reset values:
- All synchronizer stages, the edge-detect history, pending, overflow, evt_valid and evt_ch are 0; evt_ts is 0.
- Round-robin pointer last_grant = NUM_CH-1, so channel 0 has highest priority first.

Synchronizer:
- Per channel, a chain of SYNC_STAGES flops; sync_level = last stage.
- pulse[i] = sync_level[i] & ~prev[i], combinational; prev is registered.
- Example, SYNC_STAGES=2, input high before edge E1: sync_level high after E2; pulse high during cycle E2–E3.

Pending latch:
- At an edge with pulse[i]=1, pending[i] is set.
- If pending[i] is also being granted at that edge, it ends as 1: set beats clear.

Overflow:
- pulse[i]=1 while pending[i]=1 and channel i not granted that edge: overflow[i] sets.
- overflow_clr[i] clears it; a simultaneous set beats the clear.

Output slot (one register):
- Loads when !evt_valid, or when evt_valid && evt_ready.
- Load: scan pending from last_grant+1 upward, modulo NUM_CH; the first set bit k gives evt_ch=k, pending[k] cleared, last_grant=k, evt_valid=1.
- No pending bit at a load opportunity: evt_valid=0, evt_ch holds its old value.
- A freshly set pending bit is not eligible in the same edge it is set.
- While evt_valid && !evt_ready: evt_ch (and evt_ts) hold stable and evt_valid stays 1.

Throughput and latency:
- Back-to-back accepts give one event per cycle.
- Edge-to-evt_valid latency: SYNC_STAGES+2 clk edges from the first sampling edge (E4 for SYNC_STAGES=2).

Reset and wrap-around:
- Reset asserted mid-operation discards all pending and presented events immediately.
- An input already high at reset release produces one rising edge, and therefore one event.
- last_grant wraps NUM_CH-1 -> 0.

Optional Feature:
- Macro: SYNC_EVENT_TIMESTAMP_EN.
- Defined:
  - Free-running TS_W counter, reset to 0, +1 every clk, wraps.
  - On pulse[i] with pending[i] not already held, ts[i] captures the counter.
  - An overflowing pulse does not overwrite ts[i], so the oldest timestamp is kept.
  - evt_ts loads ts[k] together with evt_ch.
- Undefined: no counter, no ts storage, no evt_ts port; all other behaviour identical.

Test Plan:
1. Reset low with signal_in=4'b1111 -> sync_level=0, pending=0, overflow=0, evt_valid=0.
2. Release reset, evt_ready=1, signal_in[2] rises just before E1 (SYNC_STAGES=2) -> sync_level[2]=1 after E2, pending[2]=1 after E3, evt_valid=1 with evt_ch=2 after E4, evt_valid=0 after E5.
3. signal_in 0->4'b1111 at once, evt_ready=1 -> evt_ch sequence 0,1,2,3 on consecutive cycles. Then ch1 and ch3 pulse together (last_grant=3) -> grants 1 then 3.
4. evt_ready=0 while evt_valid=1 (evt_ch=0); ch0 toggles 0->1->0->1, edges 6 clk apart -> evt_ch holds 0, pending[0]=1, overflow[0]=1. Pulse overflow_clr[0] for one cycle -> overflow[0]=0.
5. Reset asserted while pending=4'b0110 and evt_valid=1 -> all zero asynchronously. Release with signal_in=0 -> no event ever issues.
6. With SYNC_EVENT_TIMESTAMP_EN, TS_W=4: ch1 edge registers pending at counter=14, ch0 pending at counter=2 after wrap, evt_ready=0 until both pending -> grant ch0 first (evt_ts=2), then ch1 (evt_ts=14).

Source files
------------

// File: rtl/sync_event_arbiter.sv
// -----------------------------------------------------------------------------
// sync_event_arbiter
//
// Multi-channel front end for asynchronous strobe/status inputs. Each channel
// is passed through a SYNC_STAGES-deep synchronizer followed by a rising-edge
// detector. Detected edges are latched as pending events and presented one at
// a time to a single consumer over a valid/ready handshake, chosen round-robin.
//
// Optional feature (macro SYNC_EVENT_TIMESTAMP_EN):
//   A free-running TS_W counter timestamps each newly pending event; the
//   timestamp travels with the presented event on evt_ts. Without the macro
//   there is no counter, no timestamp storage and no evt_ts port.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset, clears all state
//   signal_in     raw asynchronous inputs, one bit per channel
//   sync_level    synchronized level of each channel (last synchronizer stage)
//   evt_valid     an event is presented in the output slot
//   evt_ready     consumer accepts the event at a clk edge when evt_valid is high
//   evt_ch        channel index of the presented event
//   pending       latched events not yet granted to the output slot
//   overflow      sticky: an edge arrived while the channel was already pending
//   overflow_clr  per-channel clear of overflow (a simultaneous set wins)
//   evt_ts        timestamp of the presented event (macro builds only)
// -----------------------------------------------------------------------------
module sync_event_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TS_W        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         signal_in,
    output logic [NUM_CH-1:0]         sync_level,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(NUM_CH)-1:0] evt_ch,
    output logic [NUM_CH-1:0]         pending,
    output logic [NUM_CH-1:0]         overflow,
    input  logic [NUM_CH-1:0]         overflow_clr
`ifdef SYNC_EVENT_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]           evt_ts
`endif
);

    localparam int CH_W = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 16 || SYNC_STAGES < 2 || TS_W < 1) begin : g_param_check
        $error("sync_event_arbiter: NUM_CH must be 2..16, SYNC_STAGES >= 2, TS_W >= 1");
    end

    // Synchronizer chain: index 0 samples the raw pin, SYNC_STAGES-1 is the output.
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0]                  prev_q;
    logic [NUM_CH-1:0]                  pulse;

    logic [CH_W-1:0]   last_grant;
    logic              load;
    logic              grant_found;
    logic [CH_W-1:0]   grant_idx;
    logic [NUM_CH-1:0] grant_mask;
    logic [NUM_CH-1:0] held;
    logic [NUM_CH-1:0] pending_next;
    logic [NUM_CH-1:0] overflow_next;

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign pulse      = sync_level & ~prev_q;

    // The slot refills whenever it is empty or its event is being accepted.
    assign load = !evt_valid || evt_ready;

    // Round-robin scan starting one past the last grant, wrapping at NUM_CH.
    // Only the registered pending vector is scanned, so a bit set at this
    // edge cannot be granted until the next one.
    always_comb begin : rr_scan
        int unsigned     idx;
        logic [CH_W-1:0] idx_c;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_c       = '0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            idx = 32'(last_grant) + off;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_c = CH_W'(idx);
            if (!grant_found && pending[idx_c]) begin
                grant_found = 1'b1;
                grant_idx   = idx_c;
            end
        end
    end

    always_comb begin
        grant_mask = '0;
        if (load && grant_found) begin
            grant_mask[grant_idx] = 1'b1;
        end
    end

    // held: pending bits that remain pending after this edge's grant.
    // A new pulse always sets pending (set beats the grant's clear); it only
    // counts as an overflow when the earlier event is still being held.
    assign held          = pending & ~grant_mask;
    assign pending_next  = held | pulse;
    assign overflow_next = (pulse & held) | (overflow & ~overflow_clr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            prev_q     <= '0;
            pending    <= '0;
            overflow   <= '0;
            evt_valid  <= 1'b0;
            evt_ch     <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], signal_in};
            prev_q   <= sync_level;
            pending  <= pending_next;
            overflow <= overflow_next;
            if (load) begin
                evt_valid <= grant_found;
                if (grant_found) begin
                    evt_ch     <= grant_idx;
                    last_grant <= grant_idx;
                end
            end
        end
    end

`ifdef SYNC_EVENT_TIMESTAMP_EN
    logic [TS_W-1:0]             ts_cnt;
    logic [NUM_CH-1:0][TS_W-1:0] ts_q;
    logic [NUM_CH-1:0]           ts_capture;

    // Capture only when the pulse starts a fresh pending event; an overflowing
    // pulse keeps the older timestamp.
    assign ts_capture = pulse & ~held;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_cnt <= '0;
            ts_q   <= '0;
            evt_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (ts_capture[CH_W'(i)]) begin
                    ts_q[CH_W'(i)] <= ts_cnt;
                end
            end
            if (load && grant_found) begin
                evt_ts <= ts_q[grant_idx];
            end
        end
    end
`else
    // No timestamp path: the output slot carries only the channel index.
`endif

endmodule

// File: tb/tb_sync_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sync_event_arbiter
//
// Directed bench for sync_event_arbiter (NUM_CH=4, SYNC_STAGES=2, TS_W=4).
// A cycle-level reference model derived from the behavioural rules (sample
// history, pending set, round-robin search) is compared with the DUT on every
// falling clock edge; hand-computed literal checks pin the key timings.
// Define SYNC_EVENT_TIMESTAMP_EN to also exercise the timestamp path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sync_event_arbiter;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int TW = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] signal_in = '1;
    logic [N-1:0] sync_level;
    logic         evt_valid;
    logic         evt_ready = 1'b0;
    logic [1:0]   evt_ch;
    logic [N-1:0] pending;
    logic [N-1:0] overflow;
    logic [N-1:0] overflow_clr = '0;
`ifdef SYNC_EVENT_TIMESTAMP_EN
    logic [TW-1:0] evt_ts;
`endif

    always #5 clk = ~clk;

    sync_event_arbiter #(
        .NUM_CH      (N),
        .SYNC_STAGES (S),
        .TS_W        (TW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .signal_in    (signal_in),
        .sync_level   (sync_level),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_ch       (evt_ch),
        .pending      (pending),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
`ifdef SYNC_EVENT_TIMESTAMP_EN
        ,
        .evt_ts       (evt_ts)
`endif
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] m_hist [S];   // m_hist[0] = newest input sample
    logic [N-1:0] m_prev;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_ovf;
    logic         m_valid;
    int           m_ch;
    int           m_last;
    int           m_cnt;
    int           m_evt_ts;
    int           m_ts [N];

    task automatic m_clear();
        for (int s = 0; s < S; s++) m_hist[s] = '0;
        m_prev   = '0;
        m_pend   = '0;
        m_ovf    = '0;
        m_valid  = 1'b0;
        m_ch     = 0;
        m_last   = N - 1;
        m_cnt    = 0;
        m_evt_ts = 0;
        for (int i = 0; i < N; i++) m_ts[i] = 0;
    endtask

    task automatic m_step();
        logic [N-1:0] lvl;
        logic [N-1:0] pls;
        int           gk;
        lvl = m_hist[S-1];
        pls = lvl & ~m_prev;
        gk  = -1;
        if (!m_valid || evt_ready) begin
            for (int d = 1; d <= N; d++) begin
                if (gk < 0 && m_pend[(m_last + d) % N]) gk = (m_last + d) % N;
            end
            m_valid = (gk >= 0);
            if (gk >= 0) begin
                m_ch     = gk;
                m_last   = gk;
                m_evt_ts = m_ts[gk];
            end
        end
        for (int i = 0; i < N; i++) begin
            bit still_held;
            still_held = m_pend[i] && (i != gk);
            if (pls[i] && still_held) m_ovf[i] = 1'b1;
            else if (overflow_clr[i]) m_ovf[i] = 1'b0;
            if (pls[i] && !still_held) m_ts[i] = m_cnt;
            m_pend[i] = still_held || pls[i];
        end
        for (int s = S - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
        m_hist[0] = signal_in;
        m_prev    = lvl;
        m_cnt     = (m_cnt + 1) % (1 << TW);
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_clear();
            else m_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("m_sync_level", 32'(sync_level), 32'(m_hist[S-1]));
            check("m_pending",    32'(pending),    32'(m_pend));
            check("m_overflow",   32'(overflow),   32'(m_ovf));
            check("m_evt_valid",  32'(evt_valid),  32'(m_valid));
            check("m_evt_ch",     32'(evt_ch),     32'(m_ch));
`ifdef SYNC_EVENT_TIMESTAMP_EN
            if (m_valid) check("m_evt_ts", 32'(evt_ts), 32'(m_evt_ts));
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        // 1: reset held with all inputs high
        wait_n(2);
        check("t1_sync_level", 32'(sync_level), 32'(0));
        check("t1_pending",    32'(pending),    32'(0));
        check("t1_overflow",   32'(overflow),   32'(0));
        check("t1_evt_valid",  32'(evt_valid),  32'(0));
        signal_in = '0;
        evt_ready = 1'b1;
        reset     = 1'b1;
        wait_n(3);

        // 2: single edge on ch2, latency E2/E3/E4/E5
        signal_in = 4'b0100;
        wait_n(1);
        check("t2_e1_sync",    32'(sync_level), 32'(4'b0000));
        wait_n(1);
        check("t2_e2_sync",    32'(sync_level), 32'(4'b0100));
        check("t2_e2_pending", 32'(pending),    32'(4'b0000));
        wait_n(1);
        check("t2_e3_pending", 32'(pending),    32'(4'b0100));
        check("t2_e3_valid",   32'(evt_valid),  32'(0));
        wait_n(1);
        check("t2_e4_valid",   32'(evt_valid),  32'(1));
        check("t2_e4_ch",      32'(evt_ch),     32'(2));
        check("t2_e4_pending", 32'(pending),    32'(4'b0000));
        wait_n(1);
        check("t2_e5_valid",   32'(evt_valid),  32'(0));

        // 3: all channels at once from a fresh pointer, then ch1+ch3 together
        signal_in = '0;
        reset     = 1'b0;
        wait_n(2);
        reset = 1'b1;
        wait_n(2);
        signal_in = 4'b1111;
        wait_n(3);
        for (int k = 0; k < N; k++) begin
            wait_n(1);
            check("t3_seq_valid", 32'(evt_valid), 32'(1));
            check("t3_seq_ch",    32'(evt_ch),    32'(k));
        end
        wait_n(1);
        check("t3_seq_done", 32'(evt_valid), 32'(0));
        signal_in = 4'b0101;
        wait_n(4);
        signal_in = 4'b1111;
        wait_n(4);
        check("t3_rr_ch_a", 32'(evt_ch),    32'(1));
        check("t3_rr_va_a", 32'(evt_valid), 32'(1));
        wait_n(1);
        check("t3_rr_ch_b", 32'(evt_ch),    32'(3));
        check("t3_rr_va_b", 32'(evt_valid), 32'(1));
        wait_n(1);
        check("t3_rr_done", 32'(evt_valid), 32'(0));

        // 4: stalled slot, repeated ch0 edges 6 cycles apart, overflow and clear
        signal_in = '0;
        evt_ready = 1'b0;
        wait_n(4);
        signal_in = 4'b0001;
        wait_n(3);
        signal_in = 4'b0000;
        wait_n(3);
        signal_in = 4'b0001;
        wait_n(3);
        check("t4_hold_ch",    32'(evt_ch),   32'(0));
        check("t4_pend_1",     32'(pending),  32'(4'b0001));
        check("t4_ovf_0",      32'(overflow), 32'(4'b0000));
        signal_in = 4'b0000;
        wait_n(3);
        signal_in = 4'b0001;
        wait_n(3);
        check("t4_hold_valid", 32'(evt_valid), 32'(1));
        check("t4_hold_ch2",   32'(evt_ch),    32'(0));
        check("t4_pend_2",     32'(pending),   32'(4'b0001));
        check("t4_ovf_1",      32'(overflow),  32'(4'b0001));
        overflow_clr = 4'b0001;
        wait_n(1);
        overflow_clr = 4'b0000;
        check("t4_ovf_clr",    32'(overflow),  32'(4'b0000));
        evt_ready = 1'b1;
        wait_n(1);
        check("t4_drain_ch",   32'(evt_ch),    32'(0));
        check("t4_drain_pend", 32'(pending),   32'(4'b0000));
        check("t4_drain_val",  32'(evt_valid), 32'(1));
        wait_n(1);
        check("t4_drain_done", 32'(evt_valid), 32'(0));

        // 5: asynchronous reset with pending=0110 and a held event
        evt_ready = 1'b0;
        signal_in = '0;
        wait_n(4);
        signal_in = 4'b1000;
        wait_n(1);
        signal_in = 4'b1110;
        wait_n(4);
        check("t5_pre_pend",  32'(pending),   32'(4'b0110));
        check("t5_pre_valid", 32'(evt_valid), 32'(1));
        check("t5_pre_ch",    32'(evt_ch),    32'(3));
        #2;
        reset     = 1'b0;
        signal_in = '0;
        #1;
        check("t5_async_pend",  32'(pending),    32'(0));
        check("t5_async_valid", 32'(evt_valid),  32'(0));
        check("t5_async_sync",  32'(sync_level), 32'(0));
        check("t5_async_ch",    32'(evt_ch),     32'(0));
        wait_n(2);
        evt_ready = 1'b1;
        reset     = 1'b1;
        wait_n(8);
        check("t5_quiet_valid", 32'(evt_valid), 32'(0));
        check("t5_quiet_pend",  32'(pending),   32'(0));

        // Input already high at reset release gives exactly one event
        reset     = 1'b0;
        signal_in = 4'b1000;
        wait_n(2);
        reset = 1'b1;
        wait_n(4);
        check("t5b_valid", 32'(evt_valid), 32'(1));
        check("t5b_ch",    32'(evt_ch),    32'(3));
        wait_n(1);
        check("t5b_once",  32'(evt_valid), 32'(0));
        wait_n(4);
        check("t5b_still", 32'(evt_valid), 32'(0));

`ifdef SYNC_EVENT_TIMESTAMP_EN
        // 6: timestamps across counter wrap, ch3 occupies the slot meanwhile
        signal_in = '0;
        evt_ready = 1'b0;
        reset     = 1'b0;
        wait_n(2);
        reset = 1'b1;
        wait_n(1);
        signal_in = 4'b1000;
        wait_n(11);
        signal_in = 4'b1010;
        wait_n(4);
        signal_in = 4'b1011;
        wait_n(3);
        check("t6_pend",  32'(pending), 32'(4'b0011));
        check("t6_ch3",   32'(evt_ch),  32'(3));
        check("t6_ts3",   32'(evt_ts),  32'(3));
        evt_ready = 1'b1;
        wait_n(1);
        check("t6_ch0",   32'(evt_ch),  32'(0));
        check("t6_ts0",   32'(evt_ts),  32'(2));
        wait_n(1);
        check("t6_ch1",   32'(evt_ch),  32'(1));
        check("t6_ts1",   32'(evt_ts),  32'(14));
        wait_n(1);
        check("t6_done",  32'(evt_valid), 32'(0));
`endif

        wait_n(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
